cpu_run_controller: RTL
=======================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter DBITS, 32, data/PC width.
REQ-002 Parameter RUN_ON_RESET, 1, 1 = RUNNING after reset, 0 = HALTED after reset.
REQ-003 Parameter STEP_BITS, 16, width of the step counter.
REQ-004 One clock and one reset: the clock is clk and the reset is reset; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-009 cmd_op  input  3  000 RUN, 001 HALT, 010 STEP, 011 SET_BP, 100 CLR_BP, 101-111 reserved.
REQ-010 cmd_arg  input  DBITS  STEP: count in [STEP_BITS-1:0]; SET_BP: breakpoint PC.
REQ-011 pc_out  input  DBITS  current PC register value.
REQ-012 cpu_en  output  1  qualifies PC write, register-file write and data-memory write.
REQ-013 halted  output  1  high when state is HALTED.
REQ-014 bp_hit  output  1  sticky flag: halted by breakpoint.
REQ-015 cycle_count  output  DBITS  number of cycles with cpu_en high.

Function
REQ-016 The FSM shall have exactly three states: HALTED, RUNNING and STEPPING.
REQ-017 cmd_ready shall be 1 in HALTED and RUNNING, and 0 in STEPPING.
REQ-018 RUN accepted -> next state RUNNING, bp_hit cleared, skip flag set.
REQ-019 HALT accepted -> next state HALTED; the instruction in the accept cycle still executes.
REQ-020 STEP accepted -> next state STEPPING; the counter loads cmd_arg[STEP_BITS-1:0], and a count of 0 is treated as 1; bp_hit cleared.
REQ-021 In STEPPING:
- cpu_en = 1 every cycle.
- The counter decrements each cycle.
- In the cycle the counter equals 1, next state HALTED.
- Breakpoints are ignored.
REQ-022 SET_BP accepted -> bp_addr <= cmd_arg, bp_valid <= 1, state unchanged, effective from the next cycle.
REQ-023 CLR_BP accepted -> bp_valid <= 0, state unchanged.
REQ-024 Reserved ops are accepted with no effect.
REQ-025 Breakpoint match = RUNNING, bp_valid, pc_out == bp_addr and skip flag clear.
REQ-026 On a breakpoint match (combinational): cpu_en = 0 the same cycle, next state HALTED, bp_hit <= 1.
REQ-027 cpu_en = (RUNNING and no match) or STEPPING; cpu_en = 0 in HALTED.
REQ-028 The skip flag shall clear after the first cycle with cpu_en = 1, so that RUN from a breakpoint executes the breakpoint instruction once.
REQ-029 Breakpoint match and HALT accepted in the same cycle -> HALTED with bp_hit = 1.
REQ-030 cycle_count shall increment by 1 on every edge with cpu_en = 1, wrap from all-ones to 0, and be cleared only by reset.
REQ-031 RUN accepted while RUNNING shall only re-set the skip flag.
REQ-032 STEP accepted while RUNNING shall enter STEPPING.

Reset
REQ-033 While reset = 0, the block shall hold the following values:
- State RUNNING if RUN_ON_RESET = 1, else HALTED; halted = !RUN_ON_RESET.
- bp_valid = 0, bp_addr = 0, bp_hit = 0, skip flag = 0.
- Step counter = 0, cycle_count = 0, cmd_ready = 1.
REQ-034 Reset asserted mid-STEPPING or mid-RUNNING shall abort immediately to the reset state, with no pending command retained.

Structure
REQ-035 A shared package shall hold the cmd_op encodings, the FSM state encoding and the DBITS default.
REQ-036 The design shall be a single module with no sub-module; the breakpoint comparator and the counters are inline.

Verification
REQ-037 RUN_ON_RESET = 1, release reset, 10 cycles -> cpu_en = 1 and cycle_count = 10; then HALT -> halted = 1 one cycle later and cycle_count frozen at 11.
REQ-038 HALTED, STEP with arg = 3 -> cpu_en high exactly 3 cycles, cmd_ready = 0 during them, then halted = 1 and cycle_count += 3; STEP with arg = 0 -> exactly 1 cycle.
REQ-039 SET_BP 0x48, RUN from PC 0x40 incrementing by 4 -> cpu_en drops in the cycle pc_out = 0x48, halted = 1, bp_hit = 1; RUN again -> the instruction at 0x48 executes once and the PC advances to 0x4C.
REQ-040 Breakpoint match coinciding with HALT accepted -> halted = 1, bp_hit = 1; CLR_BP then RUN past 0x48 -> no stop.
REQ-041 Preload cycle_count to 0xFFFFFFFF via a forced run -> the next enabled cycle gives 0x00000000.
REQ-042 Assert reset in the 2nd cycle of STEP 5 -> all outputs return to reset values asynchronously; after release, no residual stepping occurs.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run controller.
// Holds the command opcode encodings, the FSM state encoding and the
// default data/PC width used by the interface and the controller.
package cpu_run_controller_pkg;

    localparam int DBITS_DEFAULT = 32;

    // Command opcodes carried on cmd_op; 3'b101..3'b111 are reserved.
    localparam logic [2:0] OP_RUN    = 3'b000;
    localparam logic [2:0] OP_HALT   = 3'b001;
    localparam logic [2:0] OP_STEP   = 3'b010;
    localparam logic [2:0] OP_SET_BP = 3'b011;
    localparam logic [2:0] OP_CLR_BP = 3'b100;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_STEPPING = 2'b10
    } run_state_e;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Command channel of the CPU run controller.
// Signals:
//   cmd_valid - command present (master -> slave)
//   cmd_ready - command accepted when valid & ready at a rising edge (slave -> master)
//   cmd_op    - opcode, see cpu_run_controller_pkg
//   cmd_arg   - STEP count in the low bits, or breakpoint PC for SET_BP
interface cpu_run_controller_if
    import cpu_run_controller_pkg::*;
#(
    parameter int DBITS = DBITS_DEFAULT
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [DBITS-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/cpu_run_controller.sv
// CPU run controller: runs, halts and single/multi-steps a CPU core and
// stops it on a single PC breakpoint.
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous, active-low reset
//   cmd         - command channel (slave side of cpu_run_controller_if)
//   pc_out      - current PC of the controlled core
//   cpu_en      - qualifies PC, register-file and data-memory writes
//   halted      - state is HALTED
//   bp_hit      - sticky: the core was halted by the breakpoint
//   cycle_count - number of cycles with cpu_en high (wraps, cleared by reset only)
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int DBITS        = DBITS_DEFAULT,
    parameter bit RUN_ON_RESET = 1'b1,
    parameter int STEP_BITS    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    cpu_run_controller_if.slave        cmd,
    input  logic [DBITS-1:0]           pc_out,
    output logic                       cpu_en,
    output logic                       halted,
    output logic                       bp_hit,
    output logic [DBITS-1:0]           cycle_count
);

    localparam run_state_e RESET_STATE = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

    run_state_e           state_r;
    logic [DBITS-1:0]     bp_addr_r;
    logic                 bp_valid_r;
    logic                 bp_hit_r;
    logic                 skip_r;
    logic [STEP_BITS-1:0] step_cnt_r;
    logic [DBITS-1:0]     cycle_count_r;

    logic                 cmd_ready_s;
    logic                 accept_s;
    logic                 bp_match_s;
    logic                 cpu_en_s;
    logic [STEP_BITS-1:0] step_load_s;

    // Handshake, breakpoint comparator and core enable.
    always_comb begin
        cmd_ready_s = (state_r != ST_STEPPING);
        accept_s    = cmd.cmd_valid && cmd_ready_s;
        // A STEP count of zero still executes one instruction.
        if (cmd.cmd_arg[STEP_BITS-1:0] == {STEP_BITS{1'b0}}) begin
            step_load_s = {{(STEP_BITS-1){1'b0}}, 1'b1};
        end else begin
            step_load_s = cmd.cmd_arg[STEP_BITS-1:0];
        end
        // skip_r masks the breakpoint for the first instruction after RUN,
        // so resuming from a breakpoint executes that instruction once.
        bp_match_s = (state_r == ST_RUNNING) && bp_valid_r &&
                     (pc_out == bp_addr_r) && !skip_r;
        case (state_r)
            ST_RUNNING:  cpu_en_s = !bp_match_s;
            ST_STEPPING: cpu_en_s = 1'b1;
            ST_HALTED:   cpu_en_s = 1'b0;
            default:     cpu_en_s = 1'b0;
        endcase
        // Never let the core write while reset is held.
        if (!reset) begin
            cpu_en_s = 1'b0;
        end else begin
            cpu_en_s = cpu_en_s;
        end
    end

    // Run-control FSM, breakpoint registers and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= RESET_STATE;
            bp_addr_r     <= {DBITS{1'b0}};
            bp_valid_r    <= 1'b0;
            bp_hit_r      <= 1'b0;
            skip_r        <= 1'b0;
            step_cnt_r    <= {STEP_BITS{1'b0}};
            cycle_count_r <= {DBITS{1'b0}};
        end else begin
            if (cpu_en_s) begin
                cycle_count_r <= cycle_count_r + {{(DBITS-1){1'b0}}, 1'b1};
                skip_r        <= 1'b0;
            end
            case (state_r)
                ST_STEPPING: begin
                    if (step_cnt_r <= {{(STEP_BITS-1){1'b0}}, 1'b1}) begin
                        step_cnt_r <= {STEP_BITS{1'b0}};
                        state_r    <= ST_HALTED;
                    end else begin
                        step_cnt_r <= step_cnt_r - {{(STEP_BITS-1){1'b0}}, 1'b1};
                    end
                end
                ST_HALTED, ST_RUNNING: begin
                    if (accept_s) begin
                        case (cmd.cmd_op)
                            OP_RUN: begin
                                state_r <= ST_RUNNING;
                                skip_r  <= 1'b1;
                                if (state_r == ST_HALTED) begin
                                    bp_hit_r <= 1'b0;
                                end
                            end
                            OP_HALT: begin
                                state_r <= ST_HALTED;
                            end
                            OP_STEP: begin
                                state_r    <= ST_STEPPING;
                                step_cnt_r <= step_load_s;
                                bp_hit_r   <= 1'b0;
                            end
                            OP_SET_BP: begin
                                bp_addr_r  <= cmd.cmd_arg;
                                bp_valid_r <= 1'b1;
                            end
                            OP_CLR_BP: begin
                                bp_valid_r <= 1'b0;
                            end
                            default: begin
                                // Reserved opcodes are consumed without effect.
                            end
                        endcase
                    end
                    // A breakpoint hit overrides the state change of any
                    // command accepted in the same cycle.
                    if (bp_match_s) begin
                        state_r  <= ST_HALTED;
                        bp_hit_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= RESET_STATE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = cmd_ready_s;
    assign cpu_en        = cpu_en_s;
    assign halted        = (state_r == ST_HALTED);
    assign bp_hit        = bp_hit_r;
    assign cycle_count   = cycle_count_r;

endmodule
